// File: rtl/pll_lock_manager.sv
// PLL lock supervisor: synchronises and debounces LOCK, gates the downstream
// reset, counts lock losses and generates phase-aligned clock-enable strobes.
module pll_lock_manager #(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int NUM_CH             = 2,
    parameter int DIV_W              = 8,
    parameter int LOSS_CNT_W         = 8
) (
    input  logic                    clock_in,
    input  logic                    reset,
    input  logic                    locked,
    input  logic                    clear_loss,
    input  logic [NUM_CH*DIV_W-1:0] div_ch,
    output logic                    rst_out,
    output logic                    ready,
    output logic [NUM_CH-1:0]       ce_out,
    output logic [LOSS_CNT_W-1:0]   loss_count,
    output logic                    lock_lost
);

    localparam int STAB_W =
        (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
    localparam logic [STAB_W-1:0] STAB_LAST =
        STAB_W'(LOCK_STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK,
        STABILIZE,
        RUN
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_s;
    logic [STAB_W-1:0]      stable_cnt;
    logic                   run;
    logic                   loss_evt;

    assign lock_s   = sync_q[SYNC_STAGES-1];
    assign run      = (state == RUN);
    assign loss_evt = run && !lock_s;

    always_ff @(posedge clock_in) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], locked};
        end
    end

    // rst_out/ready are registered with the state so they never glitch
    always_ff @(posedge clock_in) begin
        if (reset) begin
            state      <= WAIT_LOCK;
            stable_cnt <= '0;
            rst_out    <= 1'b1;
            ready      <= 1'b0;
        end else begin
            unique case (state)
                WAIT_LOCK: begin
                    stable_cnt <= '0;
                    if (lock_s) begin
                        state <= STABILIZE;
                    end
                end
                STABILIZE: begin
                    if (!lock_s) begin
                        state      <= WAIT_LOCK;
                        stable_cnt <= '0;
                    end else if (stable_cnt == STAB_LAST) begin
                        state      <= RUN;
                        stable_cnt <= '0;
                        rst_out    <= 1'b0;
                        ready      <= 1'b1;
                    end else begin
                        stable_cnt <= stable_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state   <= WAIT_LOCK;
                        rst_out <= 1'b1;
                        ready   <= 1'b0;
                    end
                end
                default: begin
                    state      <= WAIT_LOCK;
                    stable_cnt <= '0;
                    rst_out    <= 1'b1;
                    ready      <= 1'b0;
                end
            endcase
        end
    end

    // A loss on the same edge as a clear leaves exactly one recorded loss
    always_ff @(posedge clock_in) begin
        if (reset) begin
            loss_count <= '0;
            lock_lost  <= 1'b0;
        end else if (loss_evt) begin
            lock_lost <= 1'b1;
            if (clear_loss) begin
                loss_count <= LOSS_CNT_W'(1);
            end else if (!(&loss_count)) begin
                loss_count <= loss_count + 1'b1;
            end
        end else if (clear_loss) begin
            loss_count <= '0;
            lock_lost  <= 1'b0;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [DIV_W-1:0] d;
        logic [DIV_W-1:0] last;
        logic [DIV_W-1:0] cnt;
        logic             hit;

        assign d    = div_ch[i*DIV_W +: DIV_W];
        assign last = (d == '0) ? '0 : d - 1'b1;
        // >= rather than == so a lowered divisor never waits for a full wrap
        assign hit  = run && (cnt >= last);
        assign ce_out[i] = hit;

        always_ff @(posedge clock_in) begin
            if (reset || !run || hit) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule
